// File: rtl/ap1000_bp_clk_pkg.sv
// Shared definitions for the AP1000 board clock bring-up logic: the DCM
// lock sequencer state encoding and the synchronizer depth.
package ap1000_bp_clk_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    DCM_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    WAIT_DDR  = 3'd2,
    STABLE    = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } dcm_state_e;

endpackage

// File: rtl/ap1000_bp_sync2.sv
// Multi-flop level synchronizer for one asynchronous lock input.
// Resets to 0 so that an unqualified lock never looks high after reset.
module ap1000_bp_sync2
  import ap1000_bp_clk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
  end

  assign q = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/ap1000_bp_dcm_lock_sequencer.sv
// DCM bring-up sequencer: pulses the DCM reset, waits for PLB/OPB then DDR
// lock, qualifies all three locks, then releases the system reset.
// Optional retry limit with a terminal FAIL state: AP1000_DCM_RETRY_LIMIT_EN.
module ap1000_bp_dcm_lock_sequencer
  import ap1000_bp_clk_pkg::*;
#(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 20,
  parameter int RETRY_W       = 4,
  parameter int MAX_RETRIES   = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               plb_dcm_locked,
  input  logic               opb_dcm_locked,
  input  logic               ddr_fb_dcm_locked,
  output logic               plb_dcm_rst,
  output logic               sys_rst,
  output logic               clocks_ready,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost,
  output logic               dcm_fail
);

  if (RST_CYCLES < 3 || MAX_RETRIES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 ||
      RST_CYCLES > 2**CNT_W || LOCK_TIMEOUT > 2**CNT_W || STABLE_CYCLES > 2**CNT_W) begin : g_cfg_err
    $error("ap1000_bp_dcm_lock_sequencer: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic plb_s, opb_s, ddr_s;

  ap1000_bp_sync2 u_sync_plb (.clk(sys_clk), .rst_n(sys_rst_n), .d(plb_dcm_locked),    .q(plb_s));
  ap1000_bp_sync2 u_sync_opb (.clk(sys_clk), .rst_n(sys_rst_n), .d(opb_dcm_locked),    .q(opb_s));
  ap1000_bp_sync2 u_sync_ddr (.clk(sys_clk), .rst_n(sys_rst_n), .d(ddr_fb_dcm_locked), .q(ddr_s));

  dcm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             retry_req, lost_req;
  logic             pair_locked, all_locked;

  assign pair_locked = plb_s & opb_s;
  assign all_locked  = pair_locked & ddr_s;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    retry_req = 1'b0;
    lost_req  = 1'b0;
    unique case (state_q)
      DCM_RST:   if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still counts as success.
        if (pair_locked)                 state_d   = WAIT_DDR;
        else if (cnt_q == TIMEOUT_LAST)  retry_req = 1'b1;
      end
      WAIT_DDR: begin
        if (!pair_locked)                retry_req = 1'b1;
        else if (ddr_s)                  state_d   = STABLE;
        else if (cnt_q == TIMEOUT_LAST)  retry_req = 1'b1;
      end
      STABLE: begin
        if (!all_locked)                 retry_req = 1'b1;
        else if (cnt_q == STABLE_LAST)   state_d   = RUN;
      end
      RUN: begin
        if (!all_locked) begin
          retry_req = 1'b1;
          lost_req  = 1'b1;
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = DCM_RST;
    endcase

`ifdef AP1000_DCM_RETRY_LIMIT_EN
    if (retry_req) state_d = (retry_cnt == RETRY_W'(MAX_RETRIES - 1)) ? FAIL : DCM_RST;
`else
    if (retry_req) state_d = DCM_RST;
`endif
  end

  // Outputs decode the next state so they switch on the same edge as the FSM.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= DCM_RST;
      cnt_q        <= '0;
      plb_dcm_rst  <= 1'b1;
      sys_rst      <= 1'b1;
      clocks_ready <= 1'b0;
      retry_cnt    <= '0;
      lock_lost    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      plb_dcm_rst  <= (state_d == DCM_RST) || (state_d == FAIL);
      sys_rst      <= (state_d != RUN);
      clocks_ready <= (state_d == RUN);
      lock_lost    <= lock_lost | lost_req;
      if (retry_req && (retry_cnt != '1)) retry_cnt <= retry_cnt + 1'b1;
    end
  end

`ifdef AP1000_DCM_RETRY_LIMIT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) dcm_fail <= 1'b0;
    else            dcm_fail <= (state_d == FAIL);
  end
`else
  assign dcm_fail = 1'b0;
`endif

endmodule

// File: tb/tb_ap1000_bp_dcm_lock_sequencer.sv
// Directed bench for the DCM lock sequencer: nominal bring-up, lock loss,
// async reset, qualification glitch, and lock timeout / retry limit.
module tb_ap1000_bp_dcm_lock_sequencer;

  localparam int RETRY_W = 4;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n;
  logic               plb_dcm_locked, opb_dcm_locked, ddr_fb_dcm_locked;
  logic               plb_dcm_rst, sys_rst, clocks_ready, lock_lost, dcm_fail;
  logic [RETRY_W-1:0] retry_cnt;

  int cyc      = 0;
  int n_checks = 0;
  int n_bad    = 0;

  ap1000_bp_dcm_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(16),
    .CNT_W(20), .RETRY_W(RETRY_W), .MAX_RETRIES(3)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .plb_dcm_locked(plb_dcm_locked), .opb_dcm_locked(opb_dcm_locked),
    .ddr_fb_dcm_locked(ddr_fb_dcm_locked),
    .plb_dcm_rst(plb_dcm_rst), .sys_rst(sys_rst), .clocks_ready(clocks_ready),
    .retry_cnt(retry_cnt), .lock_lost(lock_lost), .dcm_fail(dcm_fail)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {plb_dcm_rst, sys_rst, clocks_ready, lock_lost, dcm_fail}
  function automatic logic [31:0] outs();
    return {27'd0, plb_dcm_rst, sys_rst, clocks_ready, lock_lost, dcm_fail};
  endfunction

  // Advance to 1 ns after rising edge n, counted from reset release.
  task automatic run_to(input int n);
    if (cyc < n) begin
      while (cyc < n) begin
        @(posedge sys_clk);
        cyc++;
      end
      #1;
    end
  endtask

  task automatic set_locks(input logic p, input logic o, input logic d);
    plb_dcm_locked    = p;
    opb_dcm_locked    = o;
    ddr_fb_dcm_locked = d;
  endtask

  task automatic restart();
    sys_rst_n = 1'b0;
    set_locks(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    logic seen;

    // Nominal bring-up
    sys_rst_n = 1'b0;
    set_locks(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge sys_clk);
    #1;
    check("in_reset_outs", outs(), 32'b11000);
    check("in_reset_retry", 32'(retry_cnt), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cyc = 0;
    run_to(3);
    check("nom_rst_c3", 32'(plb_dcm_rst), 32'd1);
    run_to(4);
    check("nom_rst_c4", 32'(plb_dcm_rst), 32'd0);
    seen = 1'b0;
    for (int c = 5; c <= 38; c++) begin
      run_to(c);
      if (c == 10) set_locks(1'b1, 1'b1, 1'b0);
      if (c == 20) set_locks(1'b1, 1'b1, 1'b1);
      seen |= plb_dcm_rst | clocks_ready;
    end
    check("nom_no_rst_no_ready", 32'(seen), 32'd0);
    check("nom_c38_outs", outs(), 32'b01000);
    run_to(39);
    check("nom_c39_outs", outs(), 32'b00100);
    check("nom_c39_retry", 32'(retry_cnt), 32'd0);

    // Lock loss in RUN: one-cycle OPB dropout
    run_to(45);
    opb_dcm_locked = 1'b0;
    run_to(46);
    opb_dcm_locked = 1'b1;
    run_to(47);
    check("loss_c47_outs", outs(), 32'b00100);
    run_to(48);
    check("loss_c48_outs", outs(), 32'b11010);
    check("loss_c48_retry", 32'(retry_cnt), 32'd1);
    run_to(69);
    check("loss_c69_ready", 32'(clocks_ready), 32'd0);
    run_to(70);
    check("loss_requal_outs", outs(), 32'b00110);

    // Async reset mid-WAIT_DDR (DDR lock withdrawn, re-enters WAIT_DDR at 83)
    run_to(75);
    ddr_fb_dcm_locked = 1'b0;
    run_to(90);
    check("wddr_c90_outs", outs(), 32'b01010);
    check("wddr_c90_retry", 32'(retry_cnt), 32'd2);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_outs", outs(), 32'b11000);
    check("async_rst_retry", 32'(retry_cnt), 32'd0);

    // Glitch during qualification: synced DDR low at STABLE count 10
    restart();
    run_to(10);
    set_locks(1'b1, 1'b1, 1'b1);
    run_to(22);
    ddr_fb_dcm_locked = 1'b0;
    run_to(23);
    ddr_fb_dcm_locked = 1'b1;
    run_to(24);
    check("glitch_c24_rst", 32'(plb_dcm_rst), 32'd0);
    run_to(25);
    check("glitch_c25_outs", outs(), 32'b11000);
    check("glitch_c25_retry", 32'(retry_cnt), 32'd1);
    seen = 1'b0;
    for (int c = 26; c <= 46; c++) begin
      run_to(c);
      seen |= clocks_ready;
    end
    check("glitch_no_early_ready", 32'(seen), 32'd0);
    run_to(47);
    check("glitch_requal_outs", outs(), 32'b00100);

    // Lock timeout, locks never assert
    restart();
    run_to(35);
    check("tmo_c35_rst", 32'(plb_dcm_rst), 32'd0);
    check("tmo_c35_retry", 32'(retry_cnt), 32'd0);
    run_to(36);
    check("tmo_c36_rst", 32'(plb_dcm_rst), 32'd1);
    check("tmo_c36_retry", 32'(retry_cnt), 32'd1);
    run_to(39);
    check("tmo_c39_rst", 32'(plb_dcm_rst), 32'd1);
    run_to(40);
    check("tmo_c40_rst", 32'(plb_dcm_rst), 32'd0);
    run_to(72);
    check("tmo_c72_retry", 32'(retry_cnt), 32'd2);
    run_to(108);
    check("tmo_c108_retry", 32'(retry_cnt), 32'd3);
`ifdef AP1000_DCM_RETRY_LIMIT_EN
    check("limit_c108_outs", outs(), 32'b11001);
    run_to(1000);
    check("limit_c1000_outs", outs(), 32'b11001);
    check("limit_c1000_retry", 32'(retry_cnt), 32'd3);
`else
    check("tmo_c108_outs", outs(), 32'b11000);
    run_to(539);
    check("tmo_c539_retry", 32'(retry_cnt), 32'd14);
    run_to(540);
    check("tmo_c540_retry", 32'(retry_cnt), 32'd15);
    run_to(544);
    check("tmo_c544_rst", 32'(plb_dcm_rst), 32'd0);
    run_to(1000);
    check("tmo_sat_retry", 32'(retry_cnt), 32'd15);
    check("tmo_c1000_fail", 32'(dcm_fail), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
